// File: rtl/imem_loader.sv
// Boot loader: receives a framed, checksummed byte stream, writes big-endian words to
// instruction memory from address 0, and releases the core reset once a frame checks out.
module imem_loader #(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned MAX_WORDS = 256
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_byte_valid,
  input  logic [7:0]        i_byte,
  output logic              o_byte_ready,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  output logic              o_core_rst_n,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err
);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StLenHi = 3'd1;
  localparam logic [2:0] StLenLo = 3'd2;
  localparam logic [2:0] StData  = 3'd3;
  localparam logic [2:0] StCksum = 3'd4;
  localparam logic [2:0] StDone  = 3'd5;
  localparam logic [2:0] StErr   = 3'd6;

  localparam logic [16:0] MaxWords = 17'(MAX_WORDS);

  logic [2:0]        state_q, state_d;
  logic [7:0]        len_hi_q, len_hi_d;
  logic [ADDR_W-1:0] last_q, last_d;
  logic [ADDR_W-1:0] word_q, word_d;
  logic [1:0]        bidx_q, bidx_d;
  logic [23:0]       shift_q, shift_d;
  logic [7:0]        sum_q, sum_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;

  logic        in_frame;
  logic        xfer;
  logic [15:0] len;
  logic [7:0]  sum_next;

  assign in_frame = (state_q == StLenHi) || (state_q == StLenLo) ||
                    (state_q == StData)  || (state_q == StCksum);
  assign xfer     = i_byte_valid && in_frame;
  assign len      = {len_hi_q, i_byte};
  assign sum_next = sum_q + i_byte;

  always_comb begin
    state_d  = state_q;
    len_hi_d = len_hi_q;
    last_d   = last_q;
    word_d   = word_q;
    bidx_d   = bidx_q;
    shift_d  = shift_q;
    sum_d    = sum_q;
    we_d     = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    case (state_q)
      StIdle, StDone, StErr: begin
        if (i_start) begin
          state_d  = StLenHi;
          len_hi_d = '0;
          last_d   = '0;
          word_d   = '0;
          bidx_d   = '0;
          shift_d  = '0;
          sum_d    = '0;
        end
      end
      StLenHi: begin
        if (xfer) begin
          len_hi_d = i_byte;
          state_d  = StLenLo;
        end
      end
      StLenLo: begin
        if (xfer) begin
          if (len == 16'd0 || {1'b0, len} > MaxWords) begin
            state_d = StErr;
          end else begin
            last_d  = ADDR_W'(len - 16'd1);
            word_d  = '0;
            bidx_d  = '0;
            state_d = StData;
          end
        end
      end
      StData: begin
        if (xfer) begin
          shift_d = {shift_q[15:0], i_byte};
          sum_d   = sum_next;
          if (bidx_q == 2'd3) begin
            // Strobe lands in the following cycle; for the last word that is the first
            // CKSUM cycle, so ready never drops.
            we_d    = 1'b1;
            addr_d  = word_q;
            wdata_d = {shift_q, i_byte};
            word_d  = word_q + ADDR_W'(1);
            bidx_d  = '0;
            if (word_q == last_q) state_d = StCksum;
          end else begin
            bidx_d = bidx_q + 2'd1;
          end
        end
      end
      StCksum: begin
        if (xfer) state_d = (sum_next == 8'd0) ? StDone : StErr;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q  <= StIdle;
      len_hi_q <= '0;
      last_q   <= '0;
      word_q   <= '0;
      bidx_q   <= '0;
      shift_q  <= '0;
      sum_q    <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      len_hi_q <= len_hi_d;
      last_q   <= last_d;
      word_q   <= word_d;
      bidx_q   <= bidx_d;
      shift_q  <= shift_d;
      sum_q    <= sum_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
    end
  end

  assign o_byte_ready = in_frame;
  assign o_busy       = in_frame;
  assign o_done       = (state_q == StDone);
  assign o_err        = (state_q == StErr);
  assign o_core_rst_n = (state_q == StDone);
  assign o_mem_we     = we_q;
  assign o_mem_addr   = addr_q;
  assign o_mem_wdata  = wdata_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: good, bad-checksum, bad-length, mid-load reset and gapped frames.
module tb_imem_loader;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       byte_valid;
  logic [7:0] byte_in;
  logic       byte_ready;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [31:0] mem_wdata;
  logic       core_rst_n;
  logic       busy;
  logic       done;
  logic       err;

  imem_loader #(.ADDR_W(8), .MAX_WORDS(256)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_start      (start),
    .i_byte_valid (byte_valid),
    .i_byte       (byte_in),
    .o_byte_ready (byte_ready),
    .o_mem_we     (mem_we),
    .o_mem_addr   (mem_addr),
    .o_mem_wdata  (mem_wdata),
    .o_core_rst_n (core_rst_n),
    .o_busy       (busy),
    .o_done       (done),
    .o_err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [31:0] st_addr[$];
  logic [31:0] st_data[$];
  int          st_cyc[$];
  logic [31:0] words[16];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mem_we) begin
      st_addr.push_back({24'd0, mem_addr});
      st_data.push_back(mem_wdata);
      st_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0;
    byte_valid = 1'b0;
    byte_in = 8'h00;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Returns #1 after the edge that accepted the byte.
  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int n;
    if (gaps) begin
      n = 0;
      while ($urandom_range(1, 0) == 1 && n < 6) begin
        byte_valid = 1'b0;
        @(posedge clk);
        #1 n++;
      end
    end
    byte_in = b;
    byte_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (byte_ready) begin
        @(posedge clk);
        #1 break;
      end
      n++;
      if (n >= 50) begin
        check("byte_accept_timeout", 32'd0, 32'd1);
        break;
      end
    end
    byte_valid = 1'b0;
  endtask

  task automatic send_frame(input int n, input logic [7:0] ck, input bit gaps,
                            input bit mid_start);
    logic [15:0] len;
    logic [31:0] w;
    len = 16'(n);
    pulse_start();
    send_byte(len[15:8], gaps);
    send_byte(len[7:0], gaps);
    for (int i = 0; i < n; i++) begin
      w = words[i];
      for (int j = 0; j < 4; j++) begin
        if (mid_start && i == 8 && j == 0) begin
          byte_valid = 1'b0;
          start = 1'b1;
          @(posedge clk);
          #1 start = 1'b0;
          check("busy_after_mid_start", {31'd0, busy}, 32'd1);
        end
        send_byte(w[31-8*j -: 8], gaps);
      end
    end
    send_byte(ck, gaps);
  endtask

  function automatic logic [7:0] calc_ck(input int n);
    logic [7:0] s;
    s = 8'd0;
    for (int i = 0; i < n; i++)
      for (int j = 0; j < 4; j++) s = s + 8'(words[i] >> (8 * j));
    return 8'(8'd0 - s);
  endfunction

  task automatic expect_strobes(input string tag, input int base, input int n);
    check({tag, "_count"}, 32'(st_addr.size() - base), 32'(n));
    for (int k = 0; k < n; k++) begin
      if (base + k < st_addr.size()) begin
        check({tag, "_addr"}, st_addr[base+k], 32'(k));
        check({tag, "_data"}, st_data[base+k], words[k]);
      end
    end
  endtask

  task automatic check_status(input string tag, input logic b, input logic d, input logic e,
                              input logic c);
    check({tag, "_busy"}, {31'd0, busy}, {31'd0, b});
    check({tag, "_done"}, {31'd0, done}, {31'd0, d});
    check({tag, "_err"}, {31'd0, err}, {31'd0, e});
    check({tag, "_core_rst_n"}, {31'd0, core_rst_n}, {31'd0, c});
  endtask

  int base;

  initial begin
    do_reset();
    check_status("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    check("reset_ready", {31'd0, byte_ready}, 32'd0);
    check("reset_we", {31'd0, mem_we}, 32'd0);
    check("reset_addr", {24'd0, mem_addr}, 32'd0);
    check("reset_wdata", mem_wdata, 32'd0);

    // Single word 24000008; data bytes sum to 0x2C, so CK=D4.
    words[0] = 32'h24000008;
    base = st_addr.size();
    send_frame(1, 8'hD4, 1'b0, 1'b0);
    check_status("t1", 1'b0, 1'b1, 1'b0, 1'b1);
    expect_strobes("t1", base, 1);

    // Three words back to back; data sum 0x198 -> CK=0x68.
    words[0] = 32'h11111111;
    words[1] = 32'h22222222;
    words[2] = 32'h33333333;
    base = st_addr.size();
    pulse_start();
    check_status("restart", 1'b1, 1'b0, 1'b0, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h03, 1'b0);
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 4; j++) send_byte(words[i][31-8*j -: 8], 1'b0);
    send_byte(8'h68, 1'b0);
    check_status("t2", 1'b0, 1'b1, 1'b0, 1'b1);
    expect_strobes("t2", base, 3);
    if (st_cyc.size() >= base + 3) begin
      check("t2_spacing01", 32'(st_cyc[base+1] - st_cyc[base]), 32'd4);
      check("t2_spacing12", 32'(st_cyc[base+2] - st_cyc[base+1]), 32'd4);
    end

    // Bad checksum, then recovery.
    words[0] = 32'h24000008;
    send_frame(1, 8'hD5, 1'b0, 1'b0);
    check_status("t3_bad", 1'b0, 1'b0, 1'b1, 1'b0);
    base = st_addr.size();
    send_frame(1, 8'hD4, 1'b0, 1'b0);
    check_status("t3_good", 1'b0, 1'b1, 1'b0, 1'b1);
    expect_strobes("t3_good", base, 1);

    // Length errors.
    base = st_addr.size();
    pulse_start();
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    check_status("t4_len0", 1'b0, 1'b0, 1'b1, 1'b0);
    pulse_start();
    send_byte(8'h01, 1'b0);
    send_byte(8'h01, 1'b0);
    check_status("t4_len257", 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (2) @(posedge clk);
    #1 check("t4_no_strobe", 32'(st_addr.size() - base), 32'd0);

    // Reset after two of four data bytes.
    base = st_addr.size();
    pulse_start();
    send_byte(8'h00, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'hAB, 1'b0);
    send_byte(8'hCD, 1'b0);
    rst_n = 1'b0;
    @(posedge clk);
    #1 check_status("t5_rst", 1'b0, 1'b0, 1'b0, 1'b0);
    check("t5_ready", {31'd0, byte_ready}, 32'd0);
    check("t5_we", {31'd0, mem_we}, 32'd0);
    check("t5_addr", {24'd0, mem_addr}, 32'd0);
    check("t5_wdata", mem_wdata, 32'd0);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 check("t5_no_strobe", 32'(st_addr.size() - base), 32'd0);
    send_frame(1, 8'hD4, 1'b0, 1'b0);
    check_status("t5_reload", 1'b0, 1'b1, 1'b0, 1'b1);
    expect_strobes("t5_reload", base, 1);

    // Sixteen words, gap-free then gapped with a stray start pulse.
    for (int i = 0; i < 16; i++) words[i] = 32'h9E3779B9 * 32'(i + 1);
    base = st_addr.size();
    send_frame(16, calc_ck(16), 1'b0, 1'b0);
    check_status("t6_nogap", 1'b0, 1'b1, 1'b0, 1'b1);
    expect_strobes("t6_nogap", base, 16);
    base = st_addr.size();
    send_frame(16, calc_ck(16), 1'b1, 1'b1);
    check_status("t6_gap", 1'b0, 1'b1, 1'b0, 1'b1);
    expect_strobes("t6_gap", base, 16);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
